// File: rtl/mux_arbiter.sv
// Two-requester round-robin arbiter owning the select of a shared 2:1 data mux.
// Define MUX_ARB_BURST_LIMIT_EN to force grant release after MAX_BURST beats.
module mux_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic             req_b,
  input  logic             last_a,
  input  logic             last_b,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic [1:0]       fsm_state,
  output logic             prio
);

  // Handshake: a beat is a cycle with gnt_x=1 and req_x=1; last_x only counts on a beat.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic             cur_req;
  logic             cur_last;
  logic [WIDTH-1:0] cur_data;
  logic             beat;
  logic             limit_hit;
  logic             release_now;

  if (MAX_BURST < 1) begin : g_bad_max_burst
    $error("mux_arbiter: MAX_BURST must be at least 1");
  end

`ifdef MUX_ARB_BURST_LIMIT_EN
  localparam int CW = $clog2(MAX_BURST + 1);
  logic [CW-1:0] beat_cnt;
`endif

  assign fsm_state = state;

  always_comb begin
    cur_req     = (state == GRANT_B) ? req_b  : req_a;
    cur_last    = (state == GRANT_B) ? last_b : last_a;
    cur_data    = (state == GRANT_B) ? data_b : data_a;
    beat        = (state != IDLE) && cur_req;
`ifdef MUX_ARB_BURST_LIMIT_EN
    limit_hit   = beat && (beat_cnt == CW'(MAX_BURST - 1));
`else
    limit_hit   = 1'b0;
`endif
    release_now = (state != IDLE) && (!cur_req || cur_last || limit_hit);
    next_state  = state;
    case (state)
      IDLE: begin
        if (req_a && (!req_b || !prio)) next_state = GRANT_A;
        else if (req_b)                 next_state = GRANT_B;
      end
      // Releasing hands straight over to a waiting peer, so no IDLE bubble.
      GRANT_A: if (release_now) next_state = req_b ? GRANT_B : IDLE;
      GRANT_B: if (release_now) next_state = req_a ? GRANT_A : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prio      <= 1'b0;
      gnt_a     <= 1'b0;
      gnt_b     <= 1'b0;
      sel       <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
`ifdef MUX_ARB_BURST_LIMIT_EN
      beat_cnt  <= '0;
`endif
    end else begin
      state     <= next_state;
      gnt_a     <= (next_state == GRANT_A);
      gnt_b     <= (next_state == GRANT_B);
      busy      <= (next_state != IDLE);
      out_valid <= beat;
      if (next_state == GRANT_A)      sel <= 1'b0;
      else if (next_state == GRANT_B) sel <= 1'b1;
      if (beat) out_data <= cur_data;
      // After a release, favour whichever side did not just hold the grant.
      if (release_now) prio <= (state == GRANT_A);
`ifdef MUX_ARB_BURST_LIMIT_EN
      if (release_now)                                 beat_cnt <= '0;
      else if (beat && (beat_cnt != CW'(MAX_BURST)))   beat_cnt <= beat_cnt + 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter: reset, bursts, contention, burst limit, abort, async reset.
module tb_mux_arbiter;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_a, req_b, last_a, last_b;
  logic [WIDTH-1:0] data_a, data_b;
  logic             gnt_a, gnt_b, sel, out_valid, busy, prio;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       fsm_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_arbiter #(.WIDTH(WIDTH), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .req_b(req_b), .last_a(last_a), .last_b(last_b),
    .data_a(data_a), .data_b(data_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .sel(sel), .out_valid(out_valid),
    .out_data(out_data), .busy(busy), .fsm_state(fsm_state), .prio(prio)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_a = 1'b0; req_b = 1'b0; last_a = 1'b0; last_b = 1'b0;
    data_a = '0; data_b = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_a = 1'b1; req_b = 1'b0; last_a = 1'b0; last_b = 1'b0;
    data_a = 8'h5C; data_b = 8'h00;
    step();
    step();
    checks++; if (gnt_a !== 1'b0) begin errors++; $display("FAIL reset_gnt_a: got %b want 0", gnt_a); end
    checks++; if (gnt_b !== 1'b0) begin errors++; $display("FAIL reset_gnt_b: got %b want 0", gnt_b); end
    checks++; if (sel !== 1'b0) begin errors++; $display("FAIL reset_sel: got %b want 0", sel); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (fsm_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", fsm_state); end
    rst_n = 1'b1;
    step();
    checks++; if (gnt_a !== 1'b1) begin errors++; $display("FAIL reset_first_gnt_a: got %b want 1", gnt_a); end
    checks++; if (sel !== 1'b0) begin errors++; $display("FAIL reset_first_sel: got %b want 0", sel); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_first_busy: got %b want 1", busy); end
  endtask

  task automatic test_single_a();
    logic [WIDTH-1:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    do_reset();
    req_a = 1'b1; data_a = vals[0];
    step();
    checks++; if (gnt_a !== 1'b1) begin errors++; $display("FAIL single_gnt_a: got %b want 1", gnt_a); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_no_valid: got %b want 0", out_valid); end
    for (int i = 0; i < 3; i++) begin
      data_a = vals[i];
      last_a = (i == 2);
      step();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid%0d: got %b want 1", i, out_valid); end
      checks++; if (out_data !== vals[i]) begin errors++; $display("FAIL single_data%0d: got %h want %h", i, out_data, vals[i]); end
      checks++; if (gnt_a !== (i != 2)) begin errors++; $display("FAIL single_gnt%0d: got %b want %b", i, gnt_a, (i != 2)); end
    end
    checks++; if (fsm_state !== 2'd0) begin errors++; $display("FAIL single_idle: got %0d want 0", fsm_state); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b want 0", busy); end
    checks++; if (prio !== 1'b1) begin errors++; $display("FAIL single_prio: got %b want 1", prio); end
    req_a = 1'b0; last_a = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_after: got %b want 0", out_valid); end
    checks++; if (out_data !== 8'h33) begin errors++; $display("FAIL single_data_hold: got %h want 33", out_data); end
  endtask

  task automatic test_contention();
    do_reset();
    req_a = 1'b1; req_b = 1'b1; last_a = 1'b1; last_b = 1'b0;
    data_a = 8'hA1; data_b = 8'hB1;
    step();
    checks++; if (gnt_a !== 1'b1 || gnt_b !== 1'b0) begin errors++; $display("FAIL cont_first: got a=%b b=%b want a=1 b=0", gnt_a, gnt_b); end
    step();
    checks++; if (gnt_a !== 1'b0 || gnt_b !== 1'b1) begin errors++; $display("FAIL cont_handover: got a=%b b=%b want a=0 b=1", gnt_a, gnt_b); end
    checks++; if (sel !== 1'b1) begin errors++; $display("FAIL cont_sel_b: got %b want 1", sel); end
    checks++; if (out_valid !== 1'b1 || out_data !== 8'hA1) begin errors++; $display("FAIL cont_data_a: got v=%b d=%h want v=1 d=a1", out_valid, out_data); end
    req_a = 1'b0; last_b = 1'b1;
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'hB1) begin errors++; $display("FAIL cont_data_b: got v=%b d=%h want v=1 d=b1", out_valid, out_data); end
    checks++; if (fsm_state !== 2'd0) begin errors++; $display("FAIL cont_idle: got %0d want 0", fsm_state); end
    checks++; if (sel !== 1'b1) begin errors++; $display("FAIL cont_sel_hold: got %b want 1", sel); end
    req_a = 1'b1; req_b = 1'b1; last_b = 1'b0; data_a = 8'hA2;
    step();
    checks++; if (gnt_a !== 1'b1 || gnt_b !== 1'b0) begin errors++; $display("FAIL cont_second: got a=%b b=%b want a=1 b=0", gnt_a, gnt_b); end
    checks++; if (sel !== 1'b0) begin errors++; $display("FAIL cont_sel_a: got %b want 0", sel); end
    req_a = 1'b0; req_b = 1'b0; last_a = 1'b0;
    step();
  endtask

  task automatic test_burst_limit();
    do_reset();
    req_a = 1'b1; req_b = 1'b1; last_a = 1'b0; last_b = 1'b1;
    data_a = 8'd1; data_b = 8'hB0;
    step();
    checks++; if (gnt_a !== 1'b1) begin errors++; $display("FAIL burst_gnt_a: got %b want 1", gnt_a); end
`ifdef MUX_ARB_BURST_LIMIT_EN
    for (int i = 1; i <= 4; i++) begin
      data_a = WIDTH'(i);
      step();
      checks++; if (out_data !== WIDTH'(i) || out_valid !== 1'b1) begin errors++; $display("FAIL burst_beat%0d: got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, WIDTH'(i)); end
      checks++; if (gnt_a !== (i < 4) || gnt_b !== (i == 4)) begin errors++; $display("FAIL burst_gnt%0d: got a=%b b=%b want a=%b b=%b", i, gnt_a, gnt_b, (i < 4), (i == 4)); end
    end
    data_a = 8'd5;
    step();
    checks++; if (out_data !== 8'hB0) begin errors++; $display("FAIL burst_b_data: got %h want b0", out_data); end
    checks++; if (gnt_a !== 1'b1 || gnt_b !== 1'b0 || sel !== 1'b0) begin errors++; $display("FAIL burst_regrant: got a=%b b=%b sel=%b want 1 0 0", gnt_a, gnt_b, sel); end
    req_b = 1'b0;
    step();
    checks++; if (out_data !== 8'd5) begin errors++; $display("FAIL burst_beat5: got %h want 05", out_data); end
    data_a = 8'd6; last_a = 1'b1;
    step();
    checks++; if (out_data !== 8'd6 || gnt_a !== 1'b0) begin errors++; $display("FAIL burst_beat6: got d=%h gnt=%b want d=06 gnt=0", out_data, gnt_a); end
`else
    for (int i = 1; i <= 6; i++) begin
      data_a = WIDTH'(i);
      last_a = (i == 6);
      step();
      checks++; if (out_data !== WIDTH'(i) || out_valid !== 1'b1) begin errors++; $display("FAIL burst_beat%0d: got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, WIDTH'(i)); end
      checks++; if (gnt_a !== (i < 6) || gnt_b !== (i == 6)) begin errors++; $display("FAIL burst_gnt%0d: got a=%b b=%b want a=%b b=%b", i, gnt_a, gnt_b, (i < 6), (i == 6)); end
    end
    req_a = 1'b0; last_a = 1'b0;
    step();
    checks++; if (out_data !== 8'hB0 || gnt_b !== 1'b0) begin errors++; $display("FAIL burst_b_done: got d=%h gnt_b=%b want d=b0 gnt_b=0", out_data, gnt_b); end
`endif
    checks++; if (fsm_state !== 2'd0) begin errors++; $display("FAIL burst_idle: got %0d want 0", fsm_state); end
    req_a = 1'b0; req_b = 1'b0; last_a = 1'b0; last_b = 1'b0;
  endtask

  task automatic test_abort();
    do_reset();
    req_a = 1'b1; last_a = 1'b1; data_a = 8'h0A;
    req_b = 1'b1; last_b = 1'b0; data_b = 8'h5A;
    step();
    step();
    checks++; if (prio !== 1'b1 || gnt_b !== 1'b1) begin errors++; $display("FAIL abort_setup: got prio=%b gnt_b=%b want 1 1", prio, gnt_b); end
    req_a = 1'b0; last_a = 1'b0;
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h5A) begin errors++; $display("FAIL abort_beat: got v=%b d=%h want v=1 d=5a", out_valid, out_data); end
    req_b = 1'b0;
    step();
    checks++; if (gnt_b !== 1'b0) begin errors++; $display("FAIL abort_gnt_b: got %b want 0", gnt_b); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 8'h5A) begin errors++; $display("FAIL abort_data_hold: got %h want 5a", out_data); end
    checks++; if (prio !== 1'b0) begin errors++; $display("FAIL abort_prio: got %b want 0", prio); end
  endtask

  task automatic test_async_reset();
    do_reset();
    req_b = 1'b1; last_b = 1'b0; data_b = 8'h77;
    step();
    step();
    checks++; if (gnt_b !== 1'b1 || out_valid !== 1'b1 || sel !== 1'b1) begin errors++; $display("FAIL async_pre: got g=%b v=%b s=%b want 1 1 1", gnt_b, out_valid, sel); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (gnt_b !== 1'b0) begin errors++; $display("FAIL async_gnt_b: got %b want 0", gnt_b); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_busy: got %b want 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_valid: got %b want 0", out_valid); end
    checks++; if (sel !== 1'b0) begin errors++; $display("FAIL async_sel: got %b want 0", sel); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL async_data: got %h want 00", out_data); end
    step();
    rst_n = 1'b1;
    checks++; if (gnt_b !== 1'b0) begin errors++; $display("FAIL async_held: got %b want 0", gnt_b); end
    step();
    checks++; if (gnt_b !== 1'b1 || sel !== 1'b1) begin errors++; $display("FAIL async_regrant: got g=%b s=%b want 1 1", gnt_b, sel); end
    req_b = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_contention();
    test_burst_limit();
    test_abort();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_arbiter.md
# mux_arbiter

Two-requester round-robin arbiter that shares a single 2:1 datapath multiplexer between sources A and B. It sequences burst transfers with a request/grant handshake, drives the mux select, and registers the selected data onto one output channel. It sits directly in front of the mux/demux datapath and is the only block allowed to drive its select line.

## Interface
- `WIDTH`, default 8: data width of each source and of the output.
- `MAX_BURST`, default 4: maximum beats per grant when the burst limit is compiled in. Must be ≥1.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_a`, `req_b` input 1: source requests; held high while the source has beats to send.
- `last_a`, `last_b` input 1: qualifies the current beat as the final beat of the burst.
- `data_a`, `data_b` input WIDTH: source data.
- `gnt_a`, `gnt_b` output 1: registered grants; never both high.
- `sel` output 1: mux select; 0 means A, 1 means B.
- `out_valid` output 1: registered beat strobe.
- `out_data` output WIDTH: registered muxed data.
- `busy` output 1: high in any GRANT state.

## Operation
- States are IDLE, GRANT_A and GRANT_B. A priority pointer `prio` (0 favours A, 1 favours B) holds the round-robin order.
- Reset values: state IDLE, `prio`=0, `gnt_a`=`gnt_b`=0, `sel`=0, `out_valid`=0, `out_data`=0, `busy`=0, beat counter 0.
- From IDLE:
  - Only `req_a` high goes to GRANT_A.
  - Only `req_b` high goes to GRANT_B.
  - Both high goes to the side favoured by `prio`.
  - Neither high stays in IDLE.
- A beat occurs in a cycle where `gnt_x`=1 and `req_x`=1. On a beat, `out_data` takes `data_x`, `out_valid` goes to 1 and the beat counter increments. In cycles with no beat, `out_valid`=0 and `out_data` holds its value.
- The grant is released at the clock edge ending:
  - a beat with `last_x`=1;
  - a cycle with `req_x`=0 (abort, no beat);
  - the MAX_BURST-th beat (see Configuration).
- On release:
  - `prio` is set to favour the other source.
  - The beat counter clears.
  - If the other source is requesting, the state moves directly to its GRANT state with no IDLE bubble; otherwise it returns to IDLE.
- `sel` follows the granted source and holds its last value in IDLE.
- Beat counter width is clog2(MAX_BURST+1). It saturates and never wraps.

## Timing
- Request to grant: `gnt_x` rises 1 cycle after the edge at which `req_x` is sampled in IDLE.
- Data latency: `out_valid`/`out_data` appear 1 cycle after the beat cycle.
- Handover: the old grant falls and the new grant rises on the same edge. There is no overlap and no gap.
- `sel` changes on the same edge as the grants, so it is stable for the whole grant period.
- A request arriving in the same cycle as the release of the other grant is granted at that release edge.
- Reset asserted mid-burst clears all outputs immediately, without waiting for `clk`. After `rst_n` deasserts, the first grant decision is made at the following edge.
- `last_x` is ignored when `req_x`=0 or `gnt_x`=0.

## Configuration
- `MUX_ARB_BURST_LIMIT_EN` defined:
  - A grant is forcibly released after MAX_BURST beats even if `last_x` was never seen.
  - The source must re-request and re-arbitrate for the rest of its burst.
- Not defined:
  - The counter logic is omitted.
  - A grant is held until a `last_x` beat or `req_x` drops, with unlimited burst length.

## Test plan
- Reset: hold `rst_n`=0 with `req_a`=1 → all outputs 0. Release reset → `gnt_a`=1 one cycle later, `sel`=0.
- Single A burst of 3 beats (`data_a`=0x11, 0x22, 0x33, `last_a` on 0x33) → `out_valid` high 3 cycles with those values at 1-cycle latency; `gnt_a` falls after the third beat; returns to IDLE.
- Simultaneous `req_a`=`req_b`=1 from reset → A granted first. After A's last beat, B is granted on the same edge with `sel`=1. The next contention is won by A.
- Burst limit (macro on, MAX_BURST=4): A sends 6 beats without `last_a` while B requests → A loses its grant after 4 beats, B is granted, and A is re-granted after B finishes. With the macro off, all 6 beats pass in one grant.
- Abort: drop `req_b` mid-grant → `gnt_b` falls next edge, no `out_valid` that cycle, `prio` favours A.
- Async reset mid-burst: pulse `rst_n` low between edges during a GRANT_B beat → `gnt_b`, `busy`, `out_valid` and `sel` clear immediately.
